fb_arbiter: RTL and testbench
=============================

# fb_arbiter

Frame-buffer port arbiter between `sync_mod` and a single-port synchronous frame-buffer RAM (128×96 cells, one cell per 8×8 screen block at 1024×768).
- During active video it owns the RAM port and streams pixel reads for the display.
- During blanking it shares the port round-robin among NREQ game-logic writers using a req/gnt handshake.
- It also produces a frame-start pulse and a frame counter that game logic uses to schedule per-frame updates.

## Interface
Parameters:
- NREQ, 4: number of writer requesters (2..8)
- DW, 8: frame-buffer cell width
- AW, 14: frame-buffer address width (FB_DEPTH = 12288)

Ports:
- Clocking and reset: one clock; reset is synchronous and active-low.
  - clk  in  1  system/pixel clock, same as `sync_mod`
  - rstn  in  1  synchronous active-low reset
- Display timing (from `sync_mod`):
  - x  in  11  pixel x
  - y  in  11  pixel y
  - video_on  in  1  active-area flag
- Writer handshake:
  - req  in  NREQ  per-writer write request
  - wr_addr  in  NREQ*AW  writer addresses; writer i uses bits [i*AW +: AW]
  - wr_data  in  NREQ*DW  writer data, packed the same way
  - gnt  out  NREQ  combinational grant, at most one bit set
- RAM port:
  - mem_we  out  1  registered RAM write enable
  - mem_addr  out  AW  registered RAM address
  - mem_wdata  out  DW  registered RAM write data
  - mem_rdata  in  DW  RAM read data, one-cycle read latency
- Pixel and frame outputs:
  - pix_data  out  DW  registered display cell value
  - pix_valid  out  1  pix_data corresponds to an active pixel
  - frame_start  out  1  one-cycle pulse on the first active pixel
  - frame_cnt  out  16  frames since reset
  - err_oob  out  1  one-cycle pulse when a granted write is dropped as out of range

## Operation
Each cycle the port is assigned from the current inputs:
- video_on=1: display read. The next mem_addr is {y[9:3], x[9:3]} and mem_we=0. gnt is all zero regardless of req.
- video_on=0 and req≠0: the round-robin winner i gets gnt[i]=1.
  - Search starts at (last_winner+1) mod NREQ.
  - A transfer occurs on the rising edge where req[i]&gnt[i]. At that edge, mem_addr, mem_wdata and mem_we=1 are loaded from writer i, and last_winner←i.
- video_on=0 and req=0: idle. mem_we←0 and mem_addr holds its value.

Writer handshake rules:
- The writer holds req, wr_addr and wr_data stable until it sees gnt.
- The writer may drop req or present new data on the cycle after the grant.
- gnt never depends on the writer's data.

Out-of-range writes:
- If wr_addr ≥ 12288 on a granted write, the write is consumed (the grant still counts) but mem_we←0.
- err_oob pulses in the next cycle.

Frame tracking:
- frame_start←1 for one cycle when video_on & x==0 & y==0.
- On that same edge frame_cnt increments, wrapping 65535→0.

Pipeline:
- pix_valid is video_on delayed 3 cycles.
- pix_data←mem_rdata at the edge where pix_valid is loaded with 1.
- When pix_valid is 0, pix_data is 0.

Reset (rstn=0 at an edge):
- All outputs and pipeline stages go to 0.
- last_winner←NREQ-1, so requester 0 wins first after reset.
- Reset mid-transfer cancels a pending write registered in the same edge.
- gnt is forced to 0 while rstn=0.

## Timing
- Read latency from (x, y, video_on) sampled at cycle t:
  - mem_addr valid in t+1
  - mem_rdata valid in t+2
  - pix_data/pix_valid valid in t+3
- Downstream logic delays hsync/vsync by 3 cycles to stay aligned.
- Write latency: a grant at cycle t puts mem_we=1 in t+1. Writes land only in cycles following a video_on=0 cycle, so they never collide with a display read.
- Throughput: one write per blanking cycle, i.e. 1344×806 − 1024×768 = 296,832 write slots per frame.
- Fairness: with all NREQ requesting continuously, each writer is granted exactly once every NREQ blanking cycles.
- Simultaneous events: video_on rising while req is held means gnt drops in that same cycle and no transfer occurs. The request stays pending and the round-robin pointer is unchanged.

## Structure
- Shared package `vga_pkg`:
  - H_ACTIVE=1024, V_ACTIVE=768, H_TOTAL=1344, V_TOTAL=806
  - CELL_SHIFT=3, FB_W=128, FB_H=96, FB_DEPTH=12288
  - PIX_LAT=3
- `sync_mod` is updated to use the same constants.
- Sub-module `rr_arbiter` (parameter N):
  - Inputs: req, enable, last_winner.
  - Outputs: one-hot gnt and winner index.
  - Purely combinational.
- The top level holds the pointer, the RAM port registers, the pixel pipeline and the frame counter.

## Test plan
- Display read: drive x=1023, y=767, video_on=1 → mem_addr=12287 and mem_we=0 next cycle. With RAM preloaded at 12287 with 0xA5, pix_data=0xA5 and pix_valid=1 three cycles after the stimulus.
- Round-robin: video_on=0, req=4'b1111 held 8 cycles → gnt sequence 0,1,2,3,0,1,2,3. mem_we=1 each following cycle with the matching writer's address and data.
- Blocking: video_on=1 with req=4'b0100 → gnt=0 and mem_we=0 throughout. On the first cycle with video_on=0, gnt=4'b0100, then a write appears the next cycle.
- Out of range: a granted write with wr_addr=12288 → mem_we=0 and err_oob=1 for one cycle. The next requester is served afterwards.
- Frame tracking: run 2 full frames (2×1344×806 cycles) from reset → exactly 2 frame_start pulses, each on the x=0, y=0 active cycle, and frame_cnt=2.
- Reset mid-operation: assert rstn=0 while writers are active and pixels are streaming → next cycle all outputs are 0. After release with req=4'b1111 and video_on=0, the first grant goes to requester 0.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared 1024x768 display timing constants and frame-buffer
//               geometry used by sync_mod, fb_arbiter and game logic.
//               One frame-buffer cell covers an 8x8 block of screen pixels.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // Display timing
    localparam int H_ACTIVE   = 1024;
    localparam int V_ACTIVE   = 768;
    localparam int H_TOTAL    = 1344;
    localparam int V_TOTAL    = 806;

    // Frame-buffer geometry: one cell per 8x8 pixel block
    localparam int CELL_SHIFT = 3;
    localparam int FB_W       = H_ACTIVE >> CELL_SHIFT;   // 128
    localparam int FB_H       = V_ACTIVE >> CELL_SHIFT;   // 96
    localparam int FB_DEPTH   = FB_W * FB_H;              // 12288

    // Cycles from (x, y, video_on) to pix_data/pix_valid
    localparam int PIX_LAT    = 3;

    typedef logic [13:0] fb_cell_addr_t;

    // Row-major cell address {cell_y, cell_x}; the 7-bit cell_x field makes
    // the row stride exactly FB_W = 128.
    function automatic fb_cell_addr_t fb_cell_addr(input logic [10:0] px,
                                                   input logic [10:0] py);
        return {py[9:3], px[9:3]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. The search for the next
//               requester starts one past last_winner and wraps modulo N.
//               Grants nothing while enable is low.
// Ports       : req         in  N   request vector
//               enable      in  1   allow a grant this cycle
//               last_winner in  IW  index of the previously served requester
//               gnt         out N   one-hot grant (all zero if none)
//               winner      out IW  index of the granted requester
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic          enable,
    input  logic [IW-1:0] last_winner,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] winner
);

    logic [IW-1:0] w_idx;
    logic          w_found;

    // Walk the N candidates in priority order; the first requester wins.
    // k runs 1..N so that last_winner itself is visited last.
    always_comb begin
        gnt     = '0;
        winner  = last_winner;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = IW'((int'(last_winner) + k) % N);
            if (enable && !w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                winner     = w_idx;
                w_found    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_arbiter
// Description : Frame-buffer port arbiter. During active video the single RAM
//               port streams display reads; during blanking it is shared
//               round-robin among NREQ writers with a req/gnt handshake.
//               Also produces a frame-start pulse and a frame counter.
// Ports       : clk, rstn            clock, synchronous active-low reset
//               x, y, video_on       display timing from sync_mod
//               req, wr_addr, wr_data, gnt   writer handshake (packed per writer)
//               mem_we, mem_addr, mem_wdata, mem_rdata   RAM port
//               pix_data, pix_valid  display cell value, 3-cycle latency
//               frame_start, frame_cnt      frame tracking
//               err_oob              pulse when a granted write is dropped
// Revision    : 1.0 - initial release
// ============================================================================
module fb_arbiter
    import vga_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int AW   = 14
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [10:0]          x,
    input  logic [10:0]          y,
    input  logic                 video_on,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   wr_addr,
    input  logic [NREQ*DW-1:0]   wr_data,
    output logic [NREQ-1:0]      gnt,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata,
    output logic [DW-1:0]        pix_data,
    output logic                 pix_valid,
    output logic                 frame_start,
    output logic [15:0]          frame_cnt,
    output logic                 err_oob
);

    localparam int IW = $clog2(NREQ);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [IW-1:0]      r_last_winner;
    logic               r_mem_we;
    logic [AW-1:0]      r_mem_addr;
    logic [DW-1:0]      r_mem_wdata;
    logic               r_err_oob;
    logic [PIX_LAT-1:0] r_vid_pipe;
    logic [DW-1:0]      r_pix_data;
    logic               r_frame_start;
    logic [15:0]        r_frame_cnt;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [NREQ-1:0]    w_gnt;
    logic [IW-1:0]      w_winner;
    logic               w_arb_en;
    logic               w_xfer;
    logic               w_oob;
    logic               w_frame_hit;
    logic [AW-1:0]      w_disp_addr;
    logic [AW-1:0]      w_sel_addr;
    logic [DW-1:0]      w_sel_data;
    logic [AW-1:0]      w_addr_arr [NREQ];
    logic [DW-1:0]      w_data_arr [NREQ];

    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_unpack
            assign w_addr_arr[i] = wr_addr[i*AW +: AW];
            assign w_data_arr[i] = wr_data[i*DW +: DW];
        end
    endgenerate

    // Writers are only served during blanking, so a write can never collide
    // with a display read.
    assign w_arb_en = !video_on;

    rr_arbiter #(
        .N (NREQ)
    ) u_rr_arbiter (
        .req         (req),
        .enable      (w_arb_en),
        .last_winner (r_last_winner),
        .gnt         (w_gnt),
        .winner      (w_winner)
    );

    assign gnt         = rstn ? w_gnt : '0;
    assign w_xfer      = |gnt;
    assign w_sel_addr  = w_addr_arr[w_winner];
    assign w_sel_data  = w_data_arr[w_winner];
    assign w_oob       = (w_sel_addr >= AW'(FB_DEPTH));
    assign w_disp_addr = AW'(fb_cell_addr(x, y));
    assign w_frame_hit = video_on && (x == 11'd0) && (y == 11'd0);

    // ------------------------------------------------------------------
    // RAM port and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_last_winner <= IW'(NREQ - 1);
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_err_oob     <= 1'b0;
        end else begin
            r_err_oob <= 1'b0;
            if (video_on) begin
                r_mem_we   <= 1'b0;
                r_mem_addr <= w_disp_addr;
            end else if (w_xfer) begin
                // An out-of-range write still consumes its turn so the
                // pointer advances and the writer is released.
                r_last_winner <= w_winner;
                if (w_oob) begin
                    r_mem_we  <= 1'b0;
                    r_err_oob <= 1'b1;
                end else begin
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= w_sel_addr;
                    r_mem_wdata <= w_sel_data;
                end
            end else begin
                r_mem_we <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel pipeline: stage 0 addresses the RAM, stage 1 is the RAM read,
    // the last stage presents the cell. pix_data is zeroed outside the
    // active area so downstream never sees stale cells in blanking.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_vid_pipe <= '0;
            r_pix_data <= '0;
        end else begin
            r_vid_pipe <= {r_vid_pipe[PIX_LAT-2:0], video_on};
            r_pix_data <= r_vid_pipe[PIX_LAT-2] ? mem_rdata : '0;
        end
    end

    // ------------------------------------------------------------------
    // Frame tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_frame_start <= w_frame_hit;
            if (w_frame_hit) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign err_oob     = r_err_oob;
    assign pix_valid   = r_vid_pipe[PIX_LAT-1];
    assign pix_data    = r_pix_data;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_arbiter
// Description : Directed self-checking bench for fb_arbiter with a behavioural
//               single-port RAM (one-cycle read latency).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int AW   = 14;

    logic                 clk;
    logic                 rstn;
    logic [10:0]          x;
    logic [10:0]          y;
    logic                 video_on;
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   wr_addr;
    logic [NREQ*DW-1:0]   wr_data;
    logic [NREQ-1:0]      gnt;
    logic                 mem_we;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic [DW-1:0]        mem_rdata;
    logic [DW-1:0]        pix_data;
    logic                 pix_valid;
    logic                 frame_start;
    logic [15:0]          frame_cnt;
    logic                 err_oob;

    int n_tests;
    int n_fail;

    fb_arbiter #(
        .NREQ (NREQ),
        .DW   (DW),
        .AW   (AW)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .x           (x),
        .y           (y),
        .video_on    (video_on),
        .req         (req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .gnt         (gnt),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt),
        .err_oob     (err_oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural frame-buffer RAM
    logic [DW-1:0] ram [0:16383];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_writer(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_addr[i*AW +: AW] = a;
        wr_data[i*DW +: DW] = d;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 16384; i++) ram[i] = '0;
        ram[12287] = 8'hA5;

        rstn = 1'b0; x = '0; y = '0; video_on = 1'b0; req = '0;
        wr_addr = '0; wr_data = '0;
        mem_rdata = '0;
        for (int i = 0; i < NREQ; i++) set_writer(i, AW'(100 + i), DW'(8'h10 + i));

        // ---------------- reset state ----------------
        step(); step();
        req = 4'b1111;
        #1;
        check("rst_gnt", 32'(gnt), 0);
        check("rst_we", 32'(mem_we), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_pix_valid", 32'(pix_valid), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        req  = '0;
        rstn = 1'b1;
        step(); step();

        // ---------------- display read ----------------
        x = 11'd1023; y = 11'd767; video_on = 1'b1;
        #1;
        check("disp_gnt_blocked", 32'(gnt), 0);
        step();                                   // t+1
        video_on = 1'b0; x = 11'd5; y = 11'd5;
        check("disp_addr", 32'(mem_addr), 12287);
        check("disp_we", 32'(mem_we), 0);
        step();                                   // t+2
        check("disp_pv_early", 32'(pix_valid), 0);
        step();                                   // t+3
        check("disp_pix_valid", 32'(pix_valid), 1);
        check("disp_pix_data", 32'(pix_data), 32'hA5);
        step();
        check("disp_pix_valid_off", 32'(pix_valid), 0);
        check("disp_pix_data_off", 32'(pix_data), 0);

        // ---------------- round-robin, all requesting ----------------
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(1 << (k % 4)));
            step();
            check($sformatf("rr_we%0d", k), 32'(mem_we), 1);
            check($sformatf("rr_addr%0d", k), 32'(mem_addr), 32'(100 + k % 4));
            check($sformatf("rr_data%0d", k), 32'(mem_wdata), 32'(8'h10 + k % 4));
        end
        req = '0;
        step();
        check("rr_idle_we", 32'(mem_we), 0);
        check("rr_idle_addr_hold", 32'(mem_addr), 103);
        check("ram_written", 32'(ram[102]), 32'h12);

        // ---------------- blocking during active video ----------------
        req = 4'b0100; video_on = 1'b1; x = 11'd8; y = 11'd16;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("blk_gnt%0d", k), 32'(gnt), 0);
            step();
            check($sformatf("blk_we%0d", k), 32'(mem_we), 0);
        end
        check("blk_disp_addr", 32'(mem_addr), 32'((2 << 7) | 1));
        video_on = 1'b0;
        #1;
        check("blk_release_gnt", 32'(gnt), 32'b0100);
        step();
        req = '0;
        check("blk_write_we", 32'(mem_we), 1);
        check("blk_write_addr", 32'(mem_addr), 102);
        step();

        // ---------------- out-of-range write (pointer at 2) ----------------
        set_writer(3, AW'(12288), 8'h77);
        set_writer(0, AW'(12287), 8'h5A);
        req = 4'b1001;
        #1;
        check("oob_gnt", 32'(gnt), 32'b1000);
        step();
        req = 4'b0001;
        check("oob_we", 32'(mem_we), 0);
        check("oob_err", 32'(err_oob), 1);
        check("oob_next_gnt", 32'(gnt), 32'b0001);
        step();
        req = '0;
        check("oob_err_pulse", 32'(err_oob), 0);
        check("edge_we", 32'(mem_we), 1);
        check("edge_addr", 32'(mem_addr), 12287);
        check("edge_data", 32'(mem_wdata), 32'h5A);
        step();
        set_writer(3, AW'(103), 8'h13);
        set_writer(0, AW'(100), 8'h10);

        // ---------------- frame tracking ----------------
        check("frm_cnt0", 32'(frame_cnt), 0);
        video_on = 1'b1; x = 11'd0; y = 11'd0;
        step();
        x = 11'd1;
        check("frm_start1", 32'(frame_start), 1);
        check("frm_cnt1", 32'(frame_cnt), 1);
        step();
        video_on = 1'b0; x = 11'd0; y = 11'd0;
        check("frm_pulse_end", 32'(frame_start), 0);
        step();
        video_on = 1'b1;
        check("frm_blank_nostart", 32'(frame_start), 0);
        step();
        video_on = 1'b0; x = 11'd16; y = 11'd8;
        check("frm_start2", 32'(frame_start), 1);
        check("frm_cnt2", 32'(frame_cnt), 2);
        step();

        // ---------------- reset mid-operation (pointer at 0) ----------------
        video_on = 1'b1;
        step(); step();
        video_on = 1'b0; req = 4'b1111;
        step();                                   // writer 1 served here
        #1;
        check("mid_gnt_pre", 32'(gnt), 32'b0100);
        rstn = 1'b0;
        #1;
        check("mid_gnt_in_rst", 32'(gnt), 0);
        step();
        check("mid_we", 32'(mem_we), 0);
        check("mid_addr", 32'(mem_addr), 0);
        check("mid_wdata", 32'(mem_wdata), 0);
        check("mid_pix_valid", 32'(pix_valid), 0);
        check("mid_pix_data", 32'(pix_data), 0);
        check("mid_frame_start", 32'(frame_start), 0);
        check("mid_frame_cnt", 32'(frame_cnt), 0);
        check("mid_err", 32'(err_oob), 0);
        rstn = 1'b1;
        #1;
        check("post_rst_gnt", 32'(gnt), 32'b0001);
        step();
        check("post_rst_we", 32'(mem_we), 1);
        check("post_rst_addr", 32'(mem_addr), 100);
        req = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
